// File: rtl/cache_ctrl_pkg.sv
// Shared types and default sizes for the write-back data cache controller.
// Holds the controller state encoding and the default field widths.
package cache_ctrl_pkg;

    localparam int DEF_TAG_W   = 25;
    localparam int DEF_INDEX_W = 3;
    localparam int DEF_LINE_W  = 128;

    typedef enum logic [2:0] {
        IDLE,
        WRITE_BACK,
        MEM_READ,
        FILL,
        FLUSH_SCAN,
        FLUSH_WB,
        FLUSH_CLEAN,
        FLUSH_DONE
    } state_e;

endpackage

// File: rtl/cache_mem_handshake.sv
// Busywait acknowledge tracker shared by every memory-request state.
// A request completes only after busywait has been seen high and then drops.
module cache_mem_handshake (
    input  logic clock,
    input  logic reset,
    input  logic req_active,
    input  logic mem_busywait,
    output logic req_done
);

    logic seen_busy_q;
    logic seen_busy_d;

    always_comb begin
        req_done    = req_active & seen_busy_q & ~mem_busywait;
        seen_busy_d = seen_busy_q | mem_busywait;
        // Clearing on completion re-arms the flag for a back-to-back request.
        if (!req_active || req_done) begin
            seen_busy_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            seen_busy_q <= 1'b0;
        end else begin
            seen_busy_q <= seen_busy_d;
        end
    end

endmodule

// File: rtl/cache_ctrl_wb_flush.sv
// Write-back, direct-mapped data cache controller with whole-cache flush.
// Handles clean/dirty misses and walks every index writing back dirty lines.
module cache_ctrl_wb_flush
    import cache_ctrl_pkg::*;
#(
    parameter int TAG_W   = DEF_TAG_W,
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int LINE_W  = DEF_LINE_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cpu_read,
    input  logic                       cpu_write,
    input  logic [TAG_W-1:0]           req_tag,
    input  logic [INDEX_W-1:0]         req_index,
    input  logic                       hit,
    input  logic                       victim_dirty,
    input  logic [TAG_W-1:0]           victim_tag,
    input  logic [LINE_W-1:0]          victim_data,
    input  logic                       flush_req,
    input  logic                       mem_busywait,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [TAG_W+INDEX_W-1:0]   mem_address,
    output logic [LINE_W-1:0]          mem_writedata,
    output logic                       busywait,
    output logic                       fill_en,
    output logic                       clean_en,
    output logic                       idx_sel,
    output logic [INDEX_W-1:0]         flush_index,
    output logic                       flush_done
);

    state_e               state_q,       state_d;
    logic [TAG_W-1:0]     miss_tag_q,    miss_tag_d;
    logic [INDEX_W-1:0]   miss_index_q,  miss_index_d;
    logic [TAG_W-1:0]     wb_tag_q,      wb_tag_d;
    logic [LINE_W-1:0]    wb_data_q,     wb_data_d;
    logic [INDEX_W-1:0]   flush_index_q, flush_index_d;

    logic mem_active;
    logic req_done;
    logic at_last;

    // Derived from state alone so the handshake does not loop back through the FSM.
    assign mem_active  = (state_q == WRITE_BACK) || (state_q == MEM_READ) || (state_q == FLUSH_WB);
    assign at_last     = (flush_index_q == {INDEX_W{1'b1}});
    assign flush_index = flush_index_q;

    cache_mem_handshake u_handshake (
        .clock        (clock),
        .reset        (reset),
        .req_active   (mem_active),
        .mem_busywait (mem_busywait),
        .req_done     (req_done)
    );

    always_comb begin
        state_d       = state_q;
        miss_tag_d    = miss_tag_q;
        miss_index_d  = miss_index_q;
        wb_tag_d      = wb_tag_q;
        wb_data_d     = wb_data_q;
        flush_index_d = flush_index_q;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        busywait      = 1'b0;
        fill_en       = 1'b0;
        clean_en      = 1'b0;
        idx_sel       = 1'b0;
        flush_done    = 1'b0;

        case (state_q)
            IDLE: begin
                // CPU traffic wins over a pending flush in the same cycle.
                if (cpu_read || cpu_write) begin
                    if (!hit) begin
                        busywait     = 1'b1;
                        miss_tag_d   = req_tag;
                        miss_index_d = req_index;
                        if (victim_dirty) begin
                            wb_tag_d  = victim_tag;
                            wb_data_d = victim_data;
                            state_d   = WRITE_BACK;
                        end else begin
                            state_d   = MEM_READ;
                        end
                    end
                end else if (flush_req) begin
                    flush_index_d = '0;
                    state_d       = FLUSH_SCAN;
                end
            end

            WRITE_BACK: begin
                busywait      = 1'b1;
                mem_write     = 1'b1;
                mem_address   = {wb_tag_q, miss_index_q};
                mem_writedata = wb_data_q;
                if (req_done) begin
                    state_d = MEM_READ;
                end
            end

            MEM_READ: begin
                busywait    = 1'b1;
                mem_read    = 1'b1;
                mem_address = {miss_tag_q, miss_index_q};
                if (req_done) begin
                    state_d = FILL;
                end
            end

            FILL: begin
                busywait = 1'b1;
                fill_en  = 1'b1;
                state_d  = IDLE;
            end

            FLUSH_SCAN: begin
                busywait = 1'b1;
                idx_sel  = 1'b1;
                if (victim_dirty) begin
                    wb_tag_d  = victim_tag;
                    wb_data_d = victim_data;
                    state_d   = FLUSH_WB;
                end else if (at_last) begin
                    state_d = FLUSH_DONE;
                end else begin
                    flush_index_d = flush_index_q + INDEX_W'(1);
                end
            end

            FLUSH_WB: begin
                busywait      = 1'b1;
                idx_sel       = 1'b1;
                mem_write     = 1'b1;
                mem_address   = {wb_tag_q, flush_index_q};
                mem_writedata = wb_data_q;
                if (req_done) begin
                    state_d = FLUSH_CLEAN;
                end
            end

            FLUSH_CLEAN: begin
                busywait = 1'b1;
                idx_sel  = 1'b1;
                clean_en = 1'b1;
                if (at_last) begin
                    state_d = FLUSH_DONE;
                end else begin
                    flush_index_d = flush_index_q + INDEX_W'(1);
                    state_d       = FLUSH_SCAN;
                end
            end

            FLUSH_DONE: begin
                busywait      = 1'b1;
                idx_sel       = 1'b1;
                flush_done    = 1'b1;
                flush_index_d = '0;
                state_d       = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            miss_tag_q    <= '0;
            miss_index_q  <= '0;
            wb_tag_q      <= '0;
            wb_data_q     <= '0;
            flush_index_q <= '0;
        end else begin
            state_q       <= state_d;
            miss_tag_q    <= miss_tag_d;
            miss_index_q  <= miss_index_d;
            wb_tag_q      <= wb_tag_d;
            wb_data_q     <= wb_data_d;
            flush_index_q <= flush_index_d;
        end
    end

endmodule

// File: tb/tb_cache_ctrl_wb_flush.sv
// Bench for cache_ctrl_wb_flush: cache-array model, busywait memory responder,
// and a queue of expected memory transactions checked as requests appear.
module tb_cache_ctrl_wb_flush;

    localparam int TAG_W   = 25;
    localparam int INDEX_W = 3;
    localparam int LINE_W  = 128;
    localparam int DEPTH   = 1 << INDEX_W;
    localparam int AW      = TAG_W + INDEX_W;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                cpu_read = 1'b0;
    logic                cpu_write = 1'b0;
    logic [TAG_W-1:0]    req_tag = '0;
    logic [INDEX_W-1:0]  req_index = '0;
    logic                hit;
    logic                victim_dirty;
    logic [TAG_W-1:0]    victim_tag;
    logic [LINE_W-1:0]   victim_data;
    logic                flush_req = 1'b0;
    logic                mem_busywait = 1'b0;
    logic                mem_read;
    logic                mem_write;
    logic [AW-1:0]       mem_address;
    logic [LINE_W-1:0]   mem_writedata;
    logic                busywait;
    logic                fill_en;
    logic                clean_en;
    logic                idx_sel;
    logic [INDEX_W-1:0]  flush_index;
    logic                flush_done;

    typedef struct {
        bit               is_write;
        logic [AW-1:0]    addr;
        logic [LINE_W-1:0] data;
    } mem_txn_t;

    mem_txn_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int mem_pre = 0;
    int mem_busy_len = 1;

    // Cache array model, read combinationally at whichever index the DUT selects.
    logic               c_valid [DEPTH];
    logic               c_dirty [DEPTH];
    logic [TAG_W-1:0]   c_tag   [DEPTH];
    logic [LINE_W-1:0]  c_data  [DEPTH];
    logic [INDEX_W-1:0] look_idx;

    always_comb begin
        look_idx     = idx_sel ? flush_index : req_index;
        hit          = c_valid[look_idx] && (c_tag[look_idx] == req_tag);
        victim_dirty = c_valid[look_idx] && c_dirty[look_idx];
        victim_tag   = c_tag[look_idx];
        victim_data  = c_data[look_idx];
    end

    always #5 clock = ~clock;

    cache_ctrl_wb_flush #(
        .TAG_W   (TAG_W),
        .INDEX_W (INDEX_W),
        .LINE_W  (LINE_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .cpu_read      (cpu_read),
        .cpu_write     (cpu_write),
        .req_tag       (req_tag),
        .req_index     (req_index),
        .hit           (hit),
        .victim_dirty  (victim_dirty),
        .victim_tag    (victim_tag),
        .victim_data   (victim_data),
        .flush_req     (flush_req),
        .mem_busywait  (mem_busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .busywait      (busywait),
        .fill_en       (fill_en),
        .clean_en      (clean_en),
        .idx_sel       (idx_sel),
        .flush_index   (flush_index),
        .flush_done    (flush_done)
    );

    function automatic logic [AW-1:0] line_addr(input logic [TAG_W-1:0] t, input logic [INDEX_W-1:0] i);
        return {t, i};
    endfunction

    function automatic logic [LINE_W-1:0] line_pattern(input int seed);
        logic [LINE_W-1:0] v;
        for (int w = 0; w < LINE_W / 32; w++) begin
            v[w*32 +: 32] = 32'hA5C3_0000 + 32'(seed * 16 + w);
        end
        return v;
    endfunction

    task automatic push_exp(input bit is_write, input logic [AW-1:0] addr, input logic [LINE_W-1:0] data);
        mem_txn_t t;
        t.is_write = is_write;
        t.addr     = addr;
        t.data     = data;
        exp_q.push_back(t);
    endtask

    // Memory responder: optional idle delay, then busywait high for mem_busy_len cycles.
    task automatic mem_responder();
        int             m_state = 0;
        int             m_cnt   = 0;
        logic           cur_wr  = 1'b0;
        logic [AW-1:0]  cur_addr = '0;
        mem_txn_t       e;
        forever begin
            @(negedge clock);
            if (reset) begin
                m_state      = 0;
                mem_busywait = 1'b0;
            end else if (m_state == 0) begin
                if (mem_read || mem_write) begin
                    checks++;
                    if (mem_read && mem_write) begin
                        errors++;
                        $display("FAIL mem_exclusive: mem_read=%b mem_write=%b, required at most one high", mem_read, mem_write);
                    end
                    cur_wr   = mem_write;
                    cur_addr = mem_address;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL mem_txn: got write=%b addr=%h, required no request", mem_write, mem_address);
                    end else begin
                        e = exp_q.pop_front();
                        if (mem_write !== e.is_write || mem_address !== e.addr ||
                            (e.is_write && mem_writedata !== e.data)) begin
                            errors++;
                            $display("FAIL mem_txn: got write=%b addr=%h data=%h, required write=%b addr=%h data=%h",
                                     mem_write, mem_address, mem_writedata, e.is_write, e.addr, e.data);
                        end
                    end
                    if (mem_pre == 0) begin
                        mem_busywait = 1'b1;
                        m_cnt        = mem_busy_len - 1;
                        m_state      = 2;
                    end else begin
                        m_cnt   = mem_pre - 1;
                        m_state = 1;
                    end
                end
            end else begin
                checks++;
                if (mem_write !== cur_wr || mem_read !== !cur_wr || mem_address !== cur_addr) begin
                    errors++;
                    $display("FAIL mem_hold: got rd=%b wr=%b addr=%h, required request held wr=%b addr=%h",
                             mem_read, mem_write, mem_address, cur_wr, cur_addr);
                end
                if (m_cnt == 0) begin
                    if (m_state == 1) begin
                        mem_busywait = 1'b1;
                        m_cnt        = mem_busy_len - 1;
                        m_state      = 2;
                    end else begin
                        mem_busywait = 1'b0;
                        m_state      = 0;
                    end
                end else begin
                    m_cnt--;
                end
            end
        end
    endtask

    // Issues one CPU access and holds it until busywait drops; fills the model line on fill_en.
    task automatic run_cpu(input bit wr, input logic [TAG_W-1:0] tag, input logic [INDEX_W-1:0] idx,
                           output int stall, output int fills);
        bit ended = 0;
        @(negedge clock);
        cpu_read  = !wr;
        cpu_write = wr;
        req_tag   = tag;
        req_index = idx;
        stall = 0;
        fills = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (fill_en) begin
                fills++;
                c_valid[req_index] = 1'b1;
                c_tag[req_index]   = req_tag;
                c_dirty[req_index] = 1'b0;
                c_data[req_index]  = line_pattern(int'(req_index) + 40);
            end
            if (!busywait) begin
                ended = 1;
                break;
            end
            stall++;
            @(negedge clock);
        end
        if (!ended) begin
            checks++;
            errors++;
            $display("FAIL cpu_timeout: busywait still %b after %0d cycles, required 0", busywait, stall);
        end
        if (wr) c_dirty[idx] = 1'b1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    // Follows a flush already in FLUSH_SCAN at the next sample point until flush_done.
    task automatic wait_flush(output int cycles, output int cleans, output logic [DEPTH-1:0] clean_mask,
                              output int gaps, output int done_idx);
        bit ended = 0;
        cycles = 0; cleans = 0; clean_mask = '0; gaps = 0; done_idx = -1;
        for (int i = 0; i < 300; i++) begin
            #1;
            cycles++;
            if (!busywait || !idx_sel) gaps++;
            if (clean_en) begin
                cleans++;
                clean_mask[flush_index] = 1'b1;
                c_dirty[flush_index]    = 1'b0;
            end
            if (flush_done) begin
                done_idx  = int'(flush_index);
                flush_req = 1'b0;
                ended     = 1;
                break;
            end
            @(negedge clock);
        end
        if (!ended) begin
            checks++;
            errors++;
            $display("FAIL flush_timeout: no flush_done after %0d cycles, required a pulse", cycles);
            flush_req = 1'b0;
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_address !== '0 || mem_writedata !== '0 ||
            busywait !== 1'b0 || fill_en !== 1'b0 || clean_en !== 1'b0 || idx_sel !== 1'b0 ||
            flush_index !== '0 || flush_done !== 1'b0) begin
            errors++;
            $display("FAIL %s: rd=%b wr=%b addr=%h wdata_nz=%b bw=%b fill=%b clean=%b sel=%b fidx=%0d done=%b, required all 0",
                     name, mem_read, mem_write, mem_address, |mem_writedata, busywait, fill_en, clean_en,
                     idx_sel, flush_index, flush_done);
        end
    endtask

    task automatic check_queue_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected memory transactions never issued, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check_idle_outputs("reset_outputs");
        reset = 1'b0;
        @(negedge clock);
        #1;
        check_idle_outputs("post_reset_idle");
        $display("txn reset: outputs checked under and after reset");
    endtask

    task automatic test_clean_miss();
        int stall, fills;
        mem_pre = 0; mem_busy_len = 5;
        push_exp(1'b0, line_addr(TAG_W'('hABC), INDEX_W'(3)), '0);
        run_cpu(1'b0, TAG_W'('hABC), INDEX_W'(3), stall, fills);
        checks++;
        // 1 lookup cycle + (busy cycles + completion cycle) + 1 fill cycle
        if (stall != 1 + (mem_busy_len + 1) + 1) begin
            errors++;
            $display("FAIL clean_miss_latency: got %0d stall cycles, required %0d", stall, mem_busy_len + 3);
        end
        checks++;
        if (fills != 1) begin
            errors++;
            $display("FAIL clean_miss_fill: got %0d fill_en pulses, required 1", fills);
        end
        check_queue_empty("clean_miss_txns");
        $display("txn clean_miss: stall=%0d fills=%0d", stall, fills);
    endtask

    task automatic test_hit();
        int stall, fills;
        run_cpu(1'b0, TAG_W'('hABC), INDEX_W'(3), stall, fills);
        checks++;
        if (stall != 0 || fills != 0) begin
            errors++;
            $display("FAIL read_hit: got stall=%0d fills=%0d, required 0 and 0", stall, fills);
        end
        $display("txn read_hit: stall=%0d", stall);
    endtask

    task automatic test_dirty_miss();
        int stall, fills;
        mem_pre = 0; mem_busy_len = 3;
        c_valid[6] = 1'b1; c_dirty[6] = 1'b1; c_tag[6] = TAG_W'('h12); c_data[6] = line_pattern(6);
        push_exp(1'b1, line_addr(TAG_W'('h12), INDEX_W'(6)), line_pattern(6));
        push_exp(1'b0, line_addr(TAG_W'('h777), INDEX_W'(6)), '0);
        run_cpu(1'b1, TAG_W'('h777), INDEX_W'(6), stall, fills);
        checks++;
        // lookup + writeback + refill + fill
        if (stall != 1 + 2 * (mem_busy_len + 1) + 1) begin
            errors++;
            $display("FAIL dirty_miss_latency: got %0d stall cycles, required %0d", stall, 2 * mem_busy_len + 4);
        end
        checks++;
        if (fills != 1) begin
            errors++;
            $display("FAIL dirty_miss_fill: got %0d fill_en pulses, required 1", fills);
        end
        check_queue_empty("dirty_miss_txns");
        $display("txn dirty_miss: stall=%0d fills=%0d", stall, fills);
    endtask

    task automatic test_late_busy();
        int stall, fills;
        mem_pre = 2; mem_busy_len = 3;
        push_exp(1'b0, line_addr(TAG_W'('h55), INDEX_W'(1)), '0);
        run_cpu(1'b0, TAG_W'('h55), INDEX_W'(1), stall, fills);
        checks++;
        if (stall != 1 + (mem_pre + mem_busy_len + 1) + 1) begin
            errors++;
            $display("FAIL late_busy_latency: got %0d stall cycles, required %0d", stall, mem_pre + mem_busy_len + 3);
        end
        check_queue_empty("late_busy_txns");
        mem_pre = 0;
        $display("txn late_busy: stall=%0d", stall);
    endtask

    task automatic test_flush();
        int cycles, cleans, gaps, done_idx;
        logic [DEPTH-1:0] mask;
        mem_pre = 0; mem_busy_len = 1;
        for (int i = 0; i < DEPTH; i++) begin
            c_valid[i] = 1'b1;
            c_dirty[i] = (i == 2) || (i == 5);
            c_tag[i]   = TAG_W'(32'h100 + i);
            c_data[i]  = line_pattern(i + 100);
        end
        push_exp(1'b1, line_addr(TAG_W'(32'h102), INDEX_W'(2)), line_pattern(102));
        push_exp(1'b1, line_addr(TAG_W'(32'h105), INDEX_W'(5)), line_pattern(105));
        @(negedge clock);
        flush_req = 1'b1;
        @(negedge clock);
        wait_flush(cycles, cleans, mask, gaps, done_idx);
        checks++;
        if (cleans != 2 || mask !== 8'b0010_0100) begin
            errors++;
            $display("FAIL flush_clean: got %0d pulses mask=%b, required 2 mask=00100100", cleans, mask);
        end
        checks++;
        if (done_idx != DEPTH - 1) begin
            errors++;
            $display("FAIL flush_done_index: got %0d, required %0d", done_idx, DEPTH - 1);
        end
        checks++;
        if (gaps != 0) begin
            errors++;
            $display("FAIL flush_busywait: got %0d cycles without busywait/idx_sel, required 0", gaps);
        end
        checks++;
        // every index scanned once, two writebacks of (busy+1) cycles, two clean cycles, one done cycle
        if (cycles != DEPTH + 2 * (mem_busy_len + 1) + 2 + 1) begin
            errors++;
            $display("FAIL flush_latency: got %0d cycles, required %0d", cycles, DEPTH + 2 * (mem_busy_len + 1) + 3);
        end
        check_queue_empty("flush_txns");
        @(negedge clock);
        #1;
        check_idle_outputs("flush_exit_idle");
        $display("txn flush_dirty: cycles=%0d cleans=%0d mask=%b", cycles, cleans, mask);

        flush_req = 1'b1;
        @(negedge clock);
        wait_flush(cycles, cleans, mask, gaps, done_idx);
        checks++;
        if (cycles != DEPTH + 1 || cleans != 0) begin
            errors++;
            $display("FAIL flush_clean_cache: got cycles=%0d cleans=%0d, required %0d and 0", cycles, cleans, DEPTH + 1);
        end
        check_queue_empty("flush_clean_txns");
        $display("txn flush_clean_cache: cycles=%0d", cycles);
    endtask

    task automatic test_reset_mid_wb();
        bit seen = 0;
        mem_pre = 0; mem_busy_len = 20;
        c_valid[4] = 1'b1; c_dirty[4] = 1'b1; c_tag[4] = TAG_W'('h2A); c_data[4] = line_pattern(4);
        push_exp(1'b1, line_addr(TAG_W'('h2A), INDEX_W'(4)), line_pattern(4));
        @(negedge clock);
        cpu_read = 1'b1; req_tag = TAG_W'('h99); req_index = INDEX_W'(4);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            #1;
            if (mem_write) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_wb_entry: mem_write never asserted, required WRITE_BACK request");
        end
        @(negedge clock);
        #1;
        reset = 1'b1;
        cpu_read = 1'b0;
        @(negedge clock);
        #1;
        check_idle_outputs("reset_mid_writeback");
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            #1;
            check_idle_outputs("after_abort_idle");
        end
        check_queue_empty("reset_wb_txns");
        c_dirty[4] = 1'b0;
        mem_busy_len = 1;
        $display("txn reset_mid_writeback: request aborted");
    endtask

    task automatic test_hit_with_flush();
        int cycles, cleans, gaps, done_idx;
        logic [DEPTH-1:0] mask;
        for (int i = 0; i < DEPTH; i++) c_dirty[i] = 1'b0;
        c_valid[3] = 1'b1; c_tag[3] = TAG_W'('hABC);
        @(negedge clock);
        cpu_read = 1'b1; req_tag = TAG_W'('hABC); req_index = INDEX_W'(3);
        flush_req = 1'b1;
        repeat (3) begin
            @(negedge clock);
            #1;
            checks++;
            if (busywait !== 1'b0 || idx_sel !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
                errors++;
                $display("FAIL hit_priority: got bw=%b sel=%b rd=%b wr=%b, required all 0", busywait, idx_sel, mem_read, mem_write);
            end
        end
        cpu_read = 1'b0;
        @(negedge clock);
        wait_flush(cycles, cleans, mask, gaps, done_idx);
        checks++;
        if (cycles != DEPTH + 1 || gaps != 0) begin
            errors++;
            $display("FAIL hit_then_flush: got cycles=%0d gaps=%0d, required %0d and 0", cycles, gaps, DEPTH + 1);
        end
        check_queue_empty("hit_flush_txns");
        $display("txn hit_then_flush: cycles=%0d", cycles);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            c_valid[i] = 1'b0;
            c_dirty[i] = 1'b0;
            c_tag[i]   = '0;
            c_data[i]  = '0;
        end
        fork
            mem_responder();
        join_none
        test_reset();
        test_clean_miss();
        test_hit();
        test_dirty_miss();
        test_late_busy();
        test_flush();
        test_reset_mid_wb();
        test_hit_with_flush();
        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
